// File: rtl/load_store_unit_if.sv
// Request/response bundle between the execute stage and load_store_unit.
// master = requester (execute), slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_err,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_err,
    output resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-only memory cycles, RMW sub-word stores.
// Ports: clk, rst_n, bus (req/resp slave), mem_* word memory port.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  load_store_unit_if.slave bus,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    RMW_WR,
    STORE,
    RESP
  } state_t;

  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [15:0] wdata_q;
  logic        ready_q;
  logic        rvalid_q;
  logic        rerr_q;
  logic [31:0] rdata_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic        mrd_q;
  logic        mwr_q;

  logic        req_err;
  logic        is_half;
  logic        is_word;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_half = bus.req_funct3[1:0] == 2'b01;
  assign is_word = bus.req_funct3[1:0] == 2'b10;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_addr >= MEM_BYTES)
      req_err = 1'b1;
    else if (bus.req_we && bus.req_funct3 >= 3'd3)
      req_err = 1'b1;
    else if (!bus.req_we &&
             bus.req_funct3 inside {3'd3, 3'd6, 3'd7})
      req_err = 1'b1;
    else if (is_half && bus.req_addr[0])
      req_err = 1'b1;
    else if (is_word && bus.req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  always_comb begin
    ld_byte = mem_read_data[{off_q, 3'b000} +: 8];
    ld_half = mem_read_data[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_read_data;
    endcase
  end

  // f3_q[0] separates SH from SB; only these two reach RMW
  always_comb begin
    st_merge = mem_read_data;
    if (f3_q[0])
      st_merge[{off_q[1], 4'b0000} +: 16] = wdata_q;
    else
      st_merge[{off_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      off_q    <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            off_q   <= bus.req_addr[1:0];
            f3_q    <= bus.req_funct3;
            wdata_q <= bus.req_wdata[15:0];
            ready_q <= 1'b0;
            if (req_err) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
            end else begin
              maddr_q <= {bus.req_addr[31:2], 2'b00};
              if (!bus.req_we) begin
                state_q <= LOAD;
                mrd_q   <= 1'b1;
              end else if (is_word) begin
                state_q  <= STORE;
                mwr_q    <= 1'b1;
                mwdata_q <= bus.req_wdata;
              end else begin
                state_q <= RMW_RD;
                mrd_q   <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          rdata_q  <= ld_ext;
          state_q  <= RESP;
          rvalid_q <= 1'b1;
          rerr_q   <= 1'b0;
        end
        RMW_RD: begin
          mwdata_q <= st_merge;
          mwr_q    <= 1'b1;
          state_q  <= RMW_WR;
        end
        RMW_WR, STORE: begin
          state_q  <= RESP;
          rvalid_q <= 1'b1;
          rerr_q   <= 1'b0;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          rerr_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rdata_q;
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;
  assign mem_read       = mrd_q;
  assign mem_write      = mwr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array model.
// Memory is a 256-word array with combinational read.
module tb_load_store_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] tbmem [256];
  logic [7:0]  rb [1024];
  logic [31:0] exp_rdata;
  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = tbmem[mem_address[9:2]];

  always @(posedge clk)
    if (mem_write) tbmem[mem_address[9:2]] <= mem_write_data;

  function automatic int acc_size(bit we, logic [2:0] f3);
    if (we) begin
      case (f3)
        3'd0: return 1;
        3'd1: return 2;
        3'd2: return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_err(bit we, logic [2:0] f3,
                               logic [31:0] a);
    int sz;
    sz = acc_size(we, f3);
    if (a >= 1024) return 1;
    if (sz == 0) return 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3,
                                         logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = acc_size(1'b0, f3);
    v = 0;
    for (int i = 0; i < sz; i++)
      v = v + (32'(rb[a + i]) << (8 * i));
    if (f3 < 4 && sz < 4 && v >= (32'd1 << (8 * sz - 1)))
      v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  function automatic logic [31:0] m_word(logic [31:0] a);
    int b;
    b = int'(a & 32'h3FC);
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic m_store(logic [2:0] f3, logic [31:0] a,
                         logic [31:0] d);
    int sz;
    sz = acc_size(1'b1, f3);
    for (int i = 0; i < sz; i++)
      rb[a + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic xact(input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int nrd,
                      output int nwr, output int nboth);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    nrd = 0;
    nwr = 0;
    nboth = 0;
    do begin
      @(negedge clk);
      lat++;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      nboth += int'(mem_read && mem_write);
    end while (!bus.resp_valid && lat < 20);
  endtask

  task automatic run_one(bit we, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] d);
    int lat, nrd, nwr, nboth, e_lat, e_rd, e_wr;
    bit e;
    e = m_err(we, f3, a);
    if (e) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!we) begin
      e_lat = 2; e_rd = 1; e_wr = 0;
      exp_rdata = m_load(f3, a);
    end else if (f3 == 3'd2) begin
      e_lat = 2; e_rd = 0; e_wr = 1;
      m_store(f3, a, d);
    end else begin
      e_lat = 3; e_rd = 1; e_wr = 1;
      m_store(f3, a, d);
    end
    xact(we, f3, a, d, lat, nrd, nwr, nboth);
    n_chk++;
    if (lat !== e_lat) begin
      n_fail++;
      $display("FAIL latency a=%h f3=%0d we=%0b got %0d exp %0d",
               a, f3, we, lat, e_lat);
    end
    n_chk++;
    if (bus.resp_err !== e) begin
      n_fail++;
      $display("FAIL resp_err a=%h f3=%0d we=%0b got %b exp %b",
               a, f3, we, bus.resp_err, e);
    end
    n_chk++;
    if (bus.resp_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL rdata a=%h f3=%0d got %h exp %h",
               a, f3, bus.resp_rdata, exp_rdata);
    end
    n_chk++;
    if (nrd !== e_rd || nwr !== e_wr || nboth !== 0) begin
      n_fail++;
      $display("FAIL memcycles a=%h rd %0d/%0d wr %0d/%0d both %0d",
               a, nrd, e_rd, nwr, e_wr, nboth);
    end
    @(negedge clk);
    n_chk++;
    if (tbmem[a[9:2]] !== m_word(a)) begin
      n_fail++;
      $display("FAIL memword a=%h got %h exp %h",
               a, tbmem[a[9:2]], m_word(a));
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs got rdy=%b v=%b e=%b exp 1 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err);
    end
    n_chk++;
    if (bus.resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h exp 0", bus.resp_rdata);
    end
    n_chk++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mem got rd=%b wr=%b a=%h d=%h exp 0",
               mem_read, mem_write, mem_address, mem_write_data);
    end
  endtask

  task automatic test_directed;
    run_one(1'b0, 3'd0, 32'h5, 32'h0);
    n_chk++;
    if (bus.resp_rdata !== 32'hFFFFFFAA) begin
      n_fail++;
      $display("FAIL lb5 got %h exp ffffffaa", bus.resp_rdata);
    end
    run_one(1'b0, 3'd5, 32'h6, 32'h0);
    run_one(1'b0, 3'd2, 32'h4, 32'h0);
    run_one(1'b1, 3'd0, 32'h6, 32'h11);
    n_chk++;
    if (tbmem[1] !== 32'h8811AABB) begin
      n_fail++;
      $display("FAIL sb6 got %h exp 8811aabb", tbmem[1]);
    end
    run_one(1'b0, 3'd1, 32'h3, 32'h0);
    run_one(1'b1, 3'd2, 32'h402, 32'h12345678);
    run_one(1'b0, 3'd3, 32'h8, 32'h0);
    run_one(1'b1, 3'd1, 32'h3FE, 32'hBEEF);
    run_one(1'b0, 3'd4, 32'h3FF, 32'h0);
    run_one(1'b0, 3'd2, 32'h400, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'($urandom_range(1016, 1100));
      else
        a = 32'($urandom_range(0, 1023));
      run_one(1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), a, $urandom);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h21;
    bus.req_wdata  = 32'h5A;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_wr_phase got mem_write=%b exp 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort got wr=%b rd=%b exp 0 0",
               mem_write, mem_read);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    @(negedge clk);
    n_chk++;
    if (tbmem[8] !== m_word(32'h20)) begin
      n_fail++;
      $display("FAIL abort_word got %h exp %h",
               tbmem[8], m_word(32'h20));
    end
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset got rdy=%b rdata=%h exp 1 0",
               bus.req_ready, bus.resp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int k, pulses;
    logic [31:0] d;
    k = 0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
      if (bus.req_ready) begin
        if (k < 3) begin
          d = $urandom;
          bus.req_valid  = 1'b1;
          bus.req_we     = 1'b1;
          bus.req_funct3 = 3'd2;
          bus.req_addr   = 32'h100 + 32'(4 * k);
          bus.req_wdata  = d;
          m_store(3'd2, 32'h100 + 32'(4 * k), d);
          k++;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    n_chk++;
    if (pulses !== 3 || k !== 3) begin
      n_fail++;
      $display("FAIL b2b_pulses got %0d (issued %0d) exp 3",
               pulses, k);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (tbmem[64 + i] !== m_word(32'h100 + 32'(4 * i))) begin
        n_fail++;
        $display("FAIL b2b_word%0d got %h exp %h", i,
                 tbmem[64 + i], m_word(32'h100 + 32'(4 * i)));
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_rdata = 32'd0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = (i == 1) ? 32'h8899AABB : $urandom;
      for (int j = 0; j < 4; j++)
        rb[4 * i + j] = 8'(tbmem[i] >> (8 * j));
    end
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_directed;
    test_random;
    test_reset_mid_rmw;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
